// File: rtl/cga_pkg.sv
// Shared CGA video-side types and helpers: fetch FSM states, VRAM geometry,
// and the character-cell to VRAM byte-address mapping.
package cga_pkg;

  localparam int   VRAM_ADDR_W = 14;
  localparam int   VRAM_DATA_W = 8;
  localparam logic MODE_TEXT   = 1'b0;
  localparam logic MODE_GFX    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    CAP  = 2'd3
  } fetch_state_t;

  // Even byte of a cell; the odd byte is this address with bit 0 set.
  // Graphics interleaves scan lines: ra[0] selects the upper 8 KB bank.
  function automatic logic [VRAM_ADDR_W-1:0] cell_addr(
    input logic [12:0] ma_lo,
    input logic        ra0,
    input logic        mode
  );
    logic [VRAM_ADDR_W-1:0] base;
    if (mode == MODE_GFX)
      base = {ra0, ma_lo[11:0], 1'b0};
    else
      base = {ma_lo, 1'b0};
    return base;
  endfunction

endpackage

// File: rtl/cga_vram_fetch.sv
// Fetches the two VRAM bytes of one character cell and presents them as one strobed beat.
// Latency: out_valid 3 clocks after the accepting edge; one request per 4 clocks.
// Backpressure: ready low while busy; a request then is dropped and flags sticky overrun.
module cga_vram_fetch
  import cga_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              char_start,
  input  logic [13:0]       ma,
  input  logic [4:0]        ra,
  input  logic              gfx_mode,
  output logic              ready,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_b0,
  output logic [DATA_W-1:0] out_b1,
  output logic              overrun,
  input  logic              overrun_clr
);

  fetch_state_t      state;
  logic [DATA_W-1:0] b0;

  // ma[13] and ra[4:1] never reach VRAM: the address space wraps at 16 KB.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ma[13], ra[4:1]};

  assign vram_we  = 1'b0;
  assign vram_din = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      vram_en   <= 1'b0;
      vram_addr <= '0;
      b0        <= '0;
      out_valid <= 1'b0;
      out_b0    <= '0;
      out_b1    <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (char_start && !ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (char_start) begin
            vram_en   <= 1'b1;
            vram_addr <= ADDR_W'(cell_addr(ma[12:0], ra[0], gfx_mode));
            ready     <= 1'b0;
            state     <= RD0;
          end
        end
        RD0: begin
          // Base is always even, so the odd byte is just bit 0 set.
          vram_addr <= vram_addr | ADDR_W'(1);
          state     <= RD1;
        end
        RD1: begin
          b0      <= vram_dout;
          vram_en <= 1'b0;
          state   <= CAP;
        end
        CAP: begin
          out_b0    <= b0;
          out_b1    <= vram_dout;
          out_valid <= 1'b1;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cga_vram_fetch.sv
// Directed bench for cga_vram_fetch with a behavioural one-cycle-latency VRAM.
module tb_cga_vram_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_start;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        gfx_mode;
  logic        ready;
  logic        vram_en;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;
  logic        out_valid;
  logic [7:0]  out_b0;
  logic [7:0]  out_b1;
  logic        overrun;
  logic        overrun_clr;

  always #5 clk = ~clk;

  cga_vram_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .char_start  (char_start),
    .ma          (ma),
    .ra          (ra),
    .gfx_mode    (gfx_mode),
    .ready       (ready),
    .vram_en     (vram_en),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_din    (vram_din),
    .vram_dout   (vram_dout),
    .out_valid   (out_valid),
    .out_b0      (out_b0),
    .out_b1      (out_b1),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  logic [7:0] mem [0:16383];
  int we_seen  = 0;
  int din_seen = 0;

  always @(posedge clk) begin
    if (vram_en) vram_dout <= mem[vram_addr];
    if (vram_we === 1'b1) we_seen++;
    if (vram_din !== 8'h00) din_seen++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent arithmetic form of the cell mapping.
  function automatic logic [13:0] exp_addr(input logic [13:0] m, input logic [4:0] r, input logic g);
    int a;
    if (g) a = (int'(r) % 2) * 8192 + (int'(m) % 4096) * 2;
    else   a = (int'(m) * 2) % 16384;
    return 14'(a);
  endfunction

  // Called #1 after a posedge with the DUT idle; returns #1 after the CAP edge.
  task automatic do_fetch(input logic [13:0] m, input logic [4:0] r, input logic g,
                          input logic [13:0] a0, input string tag);
    logic [7:0] e0, e1;
    e0 = mem[a0];
    e1 = mem[a0 | 14'd1];
    char_start = 1'b1; ma = m; ra = r; gfx_mode = g;
    @(posedge clk); #1;
    char_start = 1'b0; gfx_mode = ~g; ma = 14'($urandom); ra = 5'($urandom);
    chk({tag, "_vld_lo"}, 32'(out_valid), 32'd0);
    chk({tag, "_a0"},     32'(vram_addr), 32'(a0));
    chk({tag, "_en0"},    32'(vram_en),   32'd1);
    chk({tag, "_rdy0"},   32'(ready),     32'd0);
    @(posedge clk); #1;
    chk({tag, "_a1"},     32'(vram_addr), 32'(a0 | 14'd1));
    chk({tag, "_en1"},    32'(vram_en),   32'd1);
    @(posedge clk); #1;
    chk({tag, "_en_off"}, 32'(vram_en),   32'd0);
    chk({tag, "_vld_e"},  32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"},    32'(out_valid), 32'd1);
    chk({tag, "_b0"},     32'(out_b0),    32'(e0));
    chk({tag, "_b1"},     32'(out_b1),    32'(e1));
    chk({tag, "_rdy"},    32'(ready),     32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[14'h0246] = 8'h41; mem[14'h0247] = 8'h1F;
    mem[14'h3578] = 8'hA5; mem[14'h3579] = 8'h5A;
    mem[14'h3FFE] = 8'hC3; mem[14'h3FFF] = 8'h3C;

    reset = 1'b1; char_start = 1'b0; ma = '0; ra = '0; gfx_mode = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   32'(ready),     32'd1);
    chk("rst_en",      32'(vram_en),   32'd0);
    chk("rst_addr",    32'(vram_addr), 32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_b0",      32'(out_b0),    32'd0);
    chk("rst_b1",      32'(out_b1),    32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    chk("rst_we",      32'(vram_we),   32'd0);
    reset = 1'b0;

    do_fetch(14'h0123, 5'd0, 1'b0, 14'h0246, "text");
    do_fetch(14'h0ABC, 5'd1, 1'b1, 14'h3578, "gfx");
    do_fetch(14'h3FFF, 5'd0, 1'b0, 14'h3FFE, "wrap");
    @(posedge clk); #1;
    chk("addr_hold", 32'(vram_addr), 32'h3FFF);
    chk("vld_1cyc",  32'(out_valid), 32'd0);

    // Overrun: request on two consecutive clocks; the second is dropped.
    char_start = 1'b1; ma = 14'h0123; gfx_mode = 1'b0;
    @(posedge clk); #1;
    ma = 14'h0ABC;
    @(posedge clk); #1;
    char_start = 1'b0;
    chk("ovr_set", 32'(overrun),   32'd1);
    chk("ovr_a1",  32'(vram_addr), 32'h0247);
    @(posedge clk);
    @(posedge clk); #1;
    chk("ovr_vld", 32'(out_valid), 32'd1);
    chk("ovr_b0",  32'(out_b0),    32'h41);
    chk("ovr_b1",  32'(out_b1),    32'h1F);
    @(posedge clk); #1;
    chk("ovr_drop_en",  32'(vram_en),   32'd0);
    chk("ovr_drop_vld", 32'(out_valid), 32'd0);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Clear and a new overrun in the same cycle: set wins.
    char_start = 1'b1; ma = 14'h0123;
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    char_start = 1'b0; overrun_clr = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("ovr2_vld", 32'(out_valid), 32'd1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'd0);

    // Reset while in RD1 aborts the fetch silently.
    char_start = 1'b1; ma = 14'h0ABC; ra = 5'd1; gfx_mode = 1'b1;
    @(posedge clk); #1;
    char_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_en",  32'(vram_en),   32'd0);
    chk("mid_rst_rdy", 32'(ready),     32'd1);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_novld", 32'(out_valid), 32'd0);
    end
    do_fetch(14'h0123, 5'd0, 1'b0, 14'h0246, "after_rst");

    // 80 cells at the minimum 4-clock spacing.
    for (int i = 0; i < 80; i++) begin
      logic [13:0] m;
      logic [4:0]  r;
      logic        g;
      m = 14'($urandom_range(0, 16383));
      r = 5'($urandom_range(0, 31));
      g = 1'($urandom_range(0, 1));
      do_fetch(m, r, g, exp_addr(m, r, g), "b2b");
    end
    @(posedge clk); #1;
    chk("b2b_overrun", 32'(overrun),  32'd0);
    chk("we_never",    32'(we_seen),  32'd0);
    chk("din_zero",    32'(din_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cga_vram_fetch.md
Name: cga_vram_fetch

Overview:
- Video-side reader for the 16 KB dual-port video RAM: on each character-cell request, fetches the two bytes for that cell (text: character + attribute; graphics: two pixel bytes) through the read-only port.
- Delivers the pair to the pixel shifter as one registered, strobed beat.
- Sits between the CRTC address counters and the CGA pixel pipeline; the CPU side owns the other RAM port.

Parameters:
- ADDR_W, 14, VRAM byte address width (16384 bytes)
- DATA_W, 8, VRAM data width

Ports:
- clk  in  1  system clock; also clocks VRAM port B
- reset  in  1  synchronous, active-high
- char_start  in  1  one-cycle request to fetch a cell
- ma  in  14  CRTC memory address (word address), sampled with char_start
- ra  in  5  CRTC row address, sampled with char_start
- gfx_mode  in  1  0 = text, 1 = graphics; sampled with char_start
- ready  out  1  high when a char_start will be accepted
- vram_en  out  1  port B enable
- vram_we  out  1  port B write enable; constant 0
- vram_addr  out  14  port B address
- vram_din  out  8  port B write data; constant 0
- vram_dout  in  8  port B read data, valid one cycle after the address is presented with vram_en
- out_valid  out  1  one-cycle strobe; out_b0 and out_b1 are valid
- out_b0  out  8  text: character code; graphics: even byte
- out_b1  out  8  text: attribute; graphics: odd byte
- overrun  out  1  sticky: a char_start arrived while the block was busy
- overrun_clr  in  1  clears overrun

Behaviour:
- All outputs are registered.
- Reset values: ready=1, vram_en=0, vram_addr=0, out_valid=0, out_b0=0, out_b1=0, overrun=0, state=IDLE. vram_we and vram_din are tied to 0.
- Address mapping, computed from the inputs sampled at acceptance:
  - text: base = {ma[12:0], 1'b0}
  - graphics: base = {ra[0], ma[11:0], 1'b0}
  - byte0 address = base; byte1 address = base | 1
- FSM states: IDLE, RD0, RD1, CAP.
  - IDLE & char_start (edge E0): vram_en<=1, vram_addr<=byte0 addr, ready<=0, go to RD0.
  - RD0 (E1): RAM samples byte0; vram_addr<=byte1 addr; go to RD1.
  - RD1 (E2): capture vram_dout into b0 holding register; vram_en<=0; go to CAP.
  - CAP (E3): out_b0<=b0, out_b1<=vram_dout, out_valid<=1, ready<=1, go to IDLE.
- Latency: out_valid is high in the cycle after E3, i.e. 3 clocks after the accepting edge. Minimum request spacing is 4 clocks; a char_start in the CAP cycle is not accepted.
- out_valid is high for exactly one cycle. out_b0 and out_b1 hold their values until the next CAP.
- vram_addr holds its last value while idle. vram_en is high for exactly 2 cycles per fetch.
- char_start while ready=0: the request is ignored, overrun<=1, and the fetch in progress completes unaffected.
- overrun_clr and an overrun in the same cycle: overrun is set (set wins).
- Wrap: 14-bit arithmetic with no carry out. ma[13] is ignored in text mode; ma[13:12] are ignored in graphics mode. ma=0x1FFF in text mode gives addresses 0x3FFE/0x3FFF.
- Reset asserted mid-fetch: the next edge forces the reset values; no out_valid is emitted for the aborted fetch.
- gfx_mode changing during a fetch has no effect on that fetch.

Decomposition:
- Shared package cga_pkg holds:
  - state enum (IDLE, RD0, RD1, CAP)
  - constants VRAM_ADDR_W=14, VRAM_DATA_W=8, MODE_TEXT=0, MODE_GFX=1
  - a pure function for cell address mapping, reused by the cursor and light-pen logic
- No sub-module; a single FSM plus datapath.

Test Plan:
- Text fetch: RAM[0x0246]=0x41, RAM[0x0247]=0x1F; char_start, ma=0x0123, gfx_mode=0 -> vram_addr 0x0246 then 0x0247; out_valid 3 clocks later with out_b0=0x41, out_b1=0x1F.
- Graphics fetch: ma=0x0ABC, ra=1, gfx_mode=1 -> addresses 0x3578 and 0x3579; output bytes match RAM contents.
- Wrap: ma=0x3FFF in text mode -> addresses 0x3FFE and 0x3FFF (ma[13] ignored).
- Overrun: char_start on consecutive clocks -> first fetch completes with correct data, second is dropped, overrun=1; overrun_clr -> 0; simultaneous overrun_clr and overrun -> stays 1.
- Reset mid-fetch: assert reset in state RD1 -> next cycle vram_en=0, ready=1, no out_valid; a fresh request afterwards returns correct data.
- Back-to-back at 4-clock spacing across 80 cells with random RAM -> 80 out_valid pulses, all data correct, overrun stays 0, vram_we never 1.
